// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 sequencer: opcodes, write-mux encodings,
// FSM states and the control bundle passed from the decoder to the top.
package tiny16_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_MOV  = 4'h1;
   localparam logic [3:0] OP_LDL  = 4'h2;
   localparam logic [3:0] OP_LDU  = 4'h3;
   localparam logic [3:0] OP_ALU  = 4'h4;
   localparam logic [3:0] OP_LD   = 4'h5;
   localparam logic [3:0] OP_ST   = 4'h6;
   localparam logic [3:0] OP_PUSH = 4'h7;
   localparam logic [3:0] OP_POP  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_BZ   = 4'hA;
   localparam logic [3:0] OP_CALL = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] IN_ALU = 2'd0;
   localparam logic [1:0] IN_MEM = 2'd1;
   localparam logic [1:0] IN_IMM = 2'd2;
   localparam logic [1:0] IN_SRC = 2'd3;

   localparam logic [3:0] REG_PC = 4'd1;
   localparam logic [3:0] REG_SP = 4'd2;
   localparam logic [3:0] REG_BA = 4'd3;
   localparam logic [3:0] REG_RA = 4'd4;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEM,
      ST_CALL2,
      ST_HALT
   } state_e;

   typedef struct packed {
      logic [3:0] src_sel;
      logic [3:0] dst_sel;
      logic       in_en;
      logic       up_en;
      logic       lo_en;
      logic       pc_inc;
      logic       sp_inc;
      logic       sp_dec;
      logic [1:0] in_sel;
      logic       mem_req;
      logic       mem_we;
      logic       addr_from_dst;
      logic       halted;
   } ctrl_t;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_ST) || (op == OP_PUSH) || (op == OP_POP);
   endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the current state and IR fields into the full
// register-file / memory control bundle.
module instr_decode import tiny16_pkg::*; #(
   parameter logic [3:0] PC_IDX = REG_PC,
   parameter logic [3:0] SP_IDX = REG_SP,
   parameter logic [3:0] RA_IDX = REG_RA
) (
   input  state_e     state_i,
   input  logic [3:0] op_i,
   input  logic [3:0] rd_i,
   input  logic [3:0] rs_i,
   input  logic       z_i,
   input  logic       mem_ready_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctrl_o.dst_sel       = PC_IDX;
            ctrl_o.addr_from_dst = 1'b1;
            ctrl_o.mem_req       = 1'b1;
            ctrl_o.pc_inc        = mem_ready_i;
         end
         ST_EXEC: begin
            case (op_i)
               OP_MOV, OP_ALU: begin
                  ctrl_o.src_sel = rs_i;
                  ctrl_o.dst_sel = rd_i;
                  ctrl_o.in_sel  = (op_i == OP_MOV) ? IN_SRC : IN_ALU;
                  ctrl_o.in_en   = 1'b1;
               end
               OP_LDL, OP_LDU: begin
                  ctrl_o.dst_sel = rd_i;
                  ctrl_o.in_sel  = IN_IMM;
                  ctrl_o.lo_en   = (op_i == OP_LDL);
                  ctrl_o.up_en   = (op_i == OP_LDU);
               end
               OP_LD, OP_ST: begin
                  ctrl_o.src_sel = rs_i;
                  ctrl_o.dst_sel = rd_i;
               end
               OP_PUSH: begin
                  ctrl_o.src_sel = rs_i;
                  ctrl_o.dst_sel = SP_IDX;
               end
               OP_POP: begin
                  ctrl_o.src_sel = SP_IDX;
                  ctrl_o.dst_sel = SP_IDX;
                  ctrl_o.sp_inc  = 1'b1;
               end
               OP_JMP, OP_BZ: begin
                  ctrl_o.src_sel = rs_i;
                  ctrl_o.dst_sel = PC_IDX;
                  ctrl_o.in_sel  = IN_SRC;
                  ctrl_o.in_en   = (op_i == OP_JMP) || z_i;
               end
               OP_CALL: begin
                  // PC has already been incremented by the fetch, so RA gets the return address
                  ctrl_o.src_sel = PC_IDX;
                  ctrl_o.dst_sel = RA_IDX;
                  ctrl_o.in_sel  = IN_SRC;
                  ctrl_o.in_en   = 1'b1;
               end
               OP_NOP: ;
               default: ;
            endcase
         end
         ST_MEM: begin
            ctrl_o.mem_req = 1'b1;
            case (op_i)
               OP_LD: begin
                  ctrl_o.src_sel = rs_i;
                  ctrl_o.dst_sel = rd_i;
                  ctrl_o.in_sel  = IN_MEM;
                  ctrl_o.in_en   = mem_ready_i;
               end
               OP_ST, OP_PUSH: begin
                  ctrl_o.src_sel       = rs_i;
                  ctrl_o.dst_sel       = (op_i == OP_ST) ? rd_i : SP_IDX;
                  ctrl_o.addr_from_dst = 1'b1;
                  ctrl_o.mem_we        = 1'b1;
                  ctrl_o.sp_dec        = (op_i == OP_PUSH) && mem_ready_i;
               end
               OP_POP: begin
                  // address comes from src so dst can retarget rd for the write cycle
                  ctrl_o.src_sel = SP_IDX;
                  ctrl_o.dst_sel = mem_ready_i ? rd_i : SP_IDX;
                  ctrl_o.in_sel  = IN_MEM;
                  ctrl_o.in_en   = mem_ready_i;
               end
               default: ;
            endcase
         end
         ST_CALL2: begin
            ctrl_o.src_sel = rs_i;
            ctrl_o.dst_sel = PC_IDX;
            ctrl_o.in_sel  = IN_SRC;
            ctrl_o.in_en   = 1'b1;
         end
         ST_HALT: ctrl_o.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 16-entry register file: owns the FSM, IR and
// Z flag; the decoder turns state + IR into the control strobes.
module control_unit import tiny16_pkg::*; #(
   parameter logic [3:0] PC_IDX = REG_PC,
   parameter logic [3:0] SP_IDX = REG_SP,
   parameter logic [3:0] RA_IDX = REG_RA
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] src,
   input  logic [15:0] dst,
   input  logic        alu_zero,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic [3:0]  src_sel,
   output logic [3:0]  dst_sel,
   output logic        in_en,
   output logic        up_en,
   output logic        lo_en,
   output logic        pc_inc,
   output logic        sp_inc,
   output logic        sp_dec,
   output logic [1:0]  in_sel,
   output logic [7:0]  imm8,
   output logic [3:0]  alu_op,
   output logic        halted
);

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        z_q, z_d;
   ctrl_t       ctrl_dec, ctrl;

   instr_decode #(
      .PC_IDX (PC_IDX),
      .SP_IDX (SP_IDX),
      .RA_IDX (RA_IDX)
   ) u_decode (
      .state_i     (state_q),
      .op_i        (ir_q[15:12]),
      .rd_i        (ir_q[11:8]),
      .rs_i        (ir_q[7:4]),
      .z_i         (z_q),
      .mem_ready_i (mem_ready),
      .ctrl_o      (ctrl_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      z_d     = z_q;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (ir_q[15:12] == OP_ALU) z_d = alu_zero;
            if (is_mem_op(ir_q[15:12]))        state_d = ST_MEM;
            else if (ir_q[15:12] == OP_CALL)   state_d = ST_CALL2;
            else if (ir_q[15:12] == OP_HALT)   state_d = ST_HALT;
            else                               state_d = ST_FETCH;
         end
         ST_MEM:   if (mem_ready) state_d = ST_FETCH;
         ST_CALL2: state_d = ST_FETCH;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_FETCH;
      endcase
   end

   // Outputs are forced idle while reset is low so an in-flight request drops at once
   always_comb begin
      ctrl = '0;
      if (rst_n) ctrl = ctrl_dec;
   end

   assign mem_req   = ctrl.mem_req;
   assign mem_we    = ctrl.mem_we;
   assign mem_addr  = ctrl.addr_from_dst ? dst : src;
   assign mem_wdata = src;
   assign src_sel   = ctrl.src_sel;
   assign dst_sel   = ctrl.dst_sel;
   assign in_en     = ctrl.in_en;
   assign up_en     = ctrl.up_en;
   assign lo_en     = ctrl.lo_en;
   assign pc_inc    = ctrl.pc_inc;
   assign sp_inc    = ctrl.sp_inc;
   assign sp_dec    = ctrl.sp_dec;
   assign in_sel    = ctrl.in_sel;
   assign halted    = ctrl.halted;
   assign imm8      = ir_q[7:0];
   assign alu_op    = ir_q[3:0];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a register-file and memory model around the DUT,
// with write events and fetches scoreboarded against a directed program.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] src, dst, mem_rdata, mem_addr, mem_wdata;
   logic        alu_zero, mem_ready, mem_req, mem_we;
   logic [3:0]  src_sel, dst_sel, alu_op;
   logic        in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec, halted;
   logic [1:0]  in_sel;
   logic [7:0]  imm8;

   always #5 clk = ~clk;

   control_unit dut (
      .clk(clk), .rst_n(rst_n), .src(src), .dst(dst), .alu_zero(alu_zero),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .src_sel(src_sel), .dst_sel(dst_sel),
      .in_en(in_en), .up_en(up_en), .lo_en(lo_en), .pc_inc(pc_inc), .sp_inc(sp_inc),
      .sp_dec(sp_dec), .in_sel(in_sel), .imm8(imm8), .alu_op(alu_op), .halted(halted)
   );

   // Environment: register file, memory (0x0200 answers after 3 wait cycles), ALU = dst ^ src
   logic [15:0] rf [16];
   logic [15:0] mem [65536];
   logic [15:0] alu_res, wdata;
   int unsigned req_age = 0;
   logic        hold_mem = 1'b0;
   logic        rf_poke = 1'b0, mem_poke = 1'b0;
   logic [3:0]  rf_pidx = '0;
   logic [15:0] rf_pval = '0, mem_paddr = '0, mem_pval = '0;

   assign src       = rf[src_sel];
   assign dst       = rf[dst_sel];
   assign alu_res   = dst ^ src;
   assign alu_zero  = (alu_res == 16'h0000);
   assign mem_rdata = mem[mem_addr];
   assign mem_ready = mem_req && !hold_mem && (mem_addr != 16'h0200 || req_age >= 3);

   always_comb begin
      wdata = alu_res;
      case (in_sel)
         2'd1: wdata = mem_rdata;
         2'd2: wdata = {8'h00, imm8};
         2'd3: wdata = src;
         default: wdata = alu_res;
      endcase
   end

   always @(posedge clk) begin
      if (rf_poke)  rf[rf_pidx] <= rf_pval;
      if (mem_poke) mem[mem_paddr] <= mem_pval;
      if (in_en)    rf[dst_sel] <= wdata;
      if (lo_en)    rf[dst_sel][7:0] <= imm8;
      if (up_en)    rf[dst_sel][15:8] <= imm8;
      if (pc_inc)   rf[1] <= rf[1] + 16'd1;
      if (sp_inc)   rf[2] <= rf[2] + 16'd1;
      if (sp_dec)   rf[2] <= rf[2] - 16'd1;
      if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
      req_age <= (mem_req && !mem_ready) ? req_age + 1 : 0;
   end

   typedef struct packed {
      logic [2:0]  kind;   // 1 IN, 2 LO, 3 UP, 4 SP inc, 5 SP dec, 6 mem write
      logic [3:0]  sel;
      logic [15:0] addr;
      logic [15:0] data;
      logic [1:0]  isel;
   } ev_t;
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  gap;    // cycles since previous fetch, 0 = first fetch
   } fx_t;

   ev_t         exp_q[$];
   fx_t         fetch_q[$];
   logic [3:0]  aluop_q[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0, last_fetch = 0, slow_req_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input logic [2:0] k, input logic [3:0] s, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] i);
      ev_t e;
      e.kind = k; e.sel = s; e.addr = a; e.data = d; e.isel = i;
      exp_q.push_back(e);
   endtask

   task automatic push_f(input logic [15:0] a, input logic [7:0] g);
      fx_t f;
      f.addr = a; f.gap = g;
      fetch_q.push_back(f);
   endtask

   task automatic sb_check(input ev_t o);
      ev_t e;
      checks++;
      assert (exp_q.size() > 0) else begin
         failures++;
         $error("FAIL sb_unexpected: observed kind=%0d sel=%0h data=%0h expected=no event", o.kind, o.sel, o.data);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ev_kind", 32'(o.kind), 32'(e.kind));
         chk("ev_sel",  32'(o.sel),  32'(e.sel));
         chk("ev_addr", 32'(o.addr), 32'(e.addr));
         chk("ev_data", 32'(o.data), 32'(e.data));
         chk("ev_insel", 32'(o.isel), 32'(e.isel));
      end
   endtask

   task automatic sample();
      fx_t f;
      ev_t o;
      @(negedge clk);
      cyc++;
      if (rst_n) begin
         if (mem_req && mem_addr == 16'h0200) slow_req_cnt++;
         if (pc_inc) begin
            checks++;
            assert (fetch_q.size() > 0) else begin
               failures++;
               $error("FAIL fetch_unexpected: observed addr=%0h expected=no fetch", mem_addr);
            end
            if (fetch_q.size() > 0) begin
               f = fetch_q.pop_front();
               chk("fetch_addr", 32'(mem_addr), 32'(f.addr));
               if (f.gap != 8'd0) chk("fetch_gap", cyc - last_fetch, 32'(f.gap));
            end
            last_fetch = cyc;
         end
         if (mem_req && mem_ready && mem_we) begin
            o = '0; o.kind = 3'd6; o.addr = mem_addr; o.data = mem_wdata; sb_check(o);
         end
         if (in_en) begin
            o = '0; o.kind = 3'd1; o.sel = dst_sel; o.data = wdata; o.isel = in_sel; sb_check(o);
            if (in_sel == 2'd0) begin
               checks++;
               assert (aluop_q.size() > 0) else begin
                  failures++;
                  $error("FAIL alu_unexpected: observed alu_op=%0h expected=no ALU write", alu_op);
               end
               if (aluop_q.size() > 0) chk("alu_op", 32'(alu_op), 32'(aluop_q.pop_front()));
            end
         end
         if (lo_en) begin
            o = '0; o.kind = 3'd2; o.sel = dst_sel; o.data = {8'h00, imm8}; o.isel = in_sel; sb_check(o);
         end
         if (up_en) begin
            o = '0; o.kind = 3'd3; o.sel = dst_sel; o.data = {8'h00, imm8}; o.isel = in_sel; sb_check(o);
         end
         if (sp_inc) begin
            o = '0; o.kind = 3'd4; o.data = rf[2]; sb_check(o);
         end
         if (sp_dec) begin
            o = '0; o.kind = 3'd5; o.data = rf[2]; sb_check(o);
         end
         if (pc_inc || in_en) chk("inv_pc_write", 32'(pc_inc && in_en && dst_sel == 4'd1), 32'h0);
         if (in_en || up_en || lo_en) chk("inv_wr_onehot", 32'(in_en) + 32'(up_en) + 32'(lo_en), 32'd1);
         if (sp_inc || sp_dec) chk("inv_sp", 32'(sp_inc && sp_dec), 32'h0);
      end
   endtask

   task automatic poke_rf(input logic [3:0] i, input logic [15:0] v);
      rf_pidx = i; rf_pval = v; rf_poke = 1'b1;
      @(posedge clk); #1 rf_poke = 1'b0;
   endtask

   task automatic poke_mem(input logic [15:0] a, input logic [15:0] v);
      mem_paddr = a; mem_pval = v; mem_poke = 1'b1;
      @(posedge clk); #1 mem_poke = 1'b0;
   endtask

   logic [15:0] pa [16];
   logic [15:0] pw [16];
   logic [15:0] rinit [16];

   initial begin
      #2;
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_we",  32'(mem_we), 32'h0);
      chk("rst_halted",  32'(halted), 32'h0);
      chk("rst_sels",    32'({src_sel, dst_sel, in_sel}), 32'h0);
      chk("rst_strobes", 32'({in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec}), 32'h0);
      chk("rst_imm8",    32'(imm8), 32'h0);

      rinit = '{16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'hCAFE, 16'h0000, 16'h0200,
                16'h0010, 16'h0020, 16'h0000, 16'h5555, 16'h5555, 16'h1111, 16'h0000, 16'h0000};
      for (int i = 0; i < 16; i++) poke_rf(4'(i), rinit[i]);
      pa = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0010,
             16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0040, 16'h0041, 16'h0042, 16'h0200};
      pw = '{16'h2A5C, 16'h3A12, 16'h5370, 16'h7050, 16'h8600, 16'h1E50, 16'h9080, 16'hB090,
             16'h2740, 16'h3700, 16'h4BC3, 16'hA070, 16'h4DC5, 16'hA070, 16'hF000, 16'hBEEF};
      for (int i = 0; i < 16; i++) poke_mem(pa[i], pw[i]);

      // Reset in the middle of a stalled fetch
      hold_mem = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #2;
      chk("fetch_req",     32'(mem_req), 32'h1);
      chk("fetch_we",      32'(mem_we), 32'h0);
      chk("fetch_dst_sel", 32'(dst_sel), 32'h1);
      chk("fetch_addr0",   32'(mem_addr), 32'h0);
      chk("fetch_stall",   32'(pc_inc), 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_req_drop", 32'(mem_req), 32'h0);
      chk("async_dst_sel",  32'(dst_sel), 32'h0);
      hold_mem = 1'b0;

      push_f(16'h0000, 8'd0); push_f(16'h0001, 8'd2); push_f(16'h0002, 8'd2);
      push_f(16'h0003, 8'd6); push_f(16'h0004, 8'd3); push_f(16'h0005, 8'd3);
      push_f(16'h0006, 8'd2); push_f(16'h0010, 8'd2); push_f(16'h0020, 8'd3);
      push_f(16'h0021, 8'd2); push_f(16'h0022, 8'd2); push_f(16'h0023, 8'd2);
      push_f(16'h0040, 8'd2); push_f(16'h0041, 8'd2); push_f(16'h0042, 8'd2);
      push_ev(3'd2, 4'hA, 16'h0, 16'h005C, 2'd2);
      push_ev(3'd3, 4'hA, 16'h0, 16'h0012, 2'd2);
      push_ev(3'd1, 4'h3, 16'h0, 16'hBEEF, 2'd1);
      push_ev(3'd6, 4'h0, 16'h0100, 16'hCAFE, 2'd0);
      push_ev(3'd5, 4'h0, 16'h0, 16'h0100, 2'd0);
      push_ev(3'd4, 4'h0, 16'h0, 16'h00FF, 2'd0);
      push_ev(3'd1, 4'h6, 16'h0, 16'hCAFE, 2'd1);
      push_ev(3'd1, 4'hE, 16'h0, 16'hCAFE, 2'd3);
      push_ev(3'd1, 4'h1, 16'h0, 16'h0010, 2'd3);
      push_ev(3'd1, 4'h4, 16'h0, 16'h0011, 2'd3);
      push_ev(3'd1, 4'h1, 16'h0, 16'h0020, 2'd3);
      push_ev(3'd2, 4'h7, 16'h0, 16'h0040, 2'd2);
      push_ev(3'd3, 4'h7, 16'h0, 16'h0000, 2'd2);
      push_ev(3'd1, 4'hB, 16'h0, 16'h0000, 2'd0);
      push_ev(3'd1, 4'h1, 16'h0, 16'h0040, 2'd3);
      push_ev(3'd1, 4'hD, 16'h0, 16'h4444, 2'd0);
      aluop_q.push_back(4'h3);
      aluop_q.push_back(4'h5);

      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 600 && !halted; i++) sample();
      chk("halt_reached", 32'(halted), 32'h1);
      for (int i = 0; i < 8; i++) begin
         sample();
         chk("halt_no_req", 32'(mem_req), 32'h0);
         chk("halt_held",   32'(halted), 32'h1);
      end

      chk("sb_events_left",  32'(exp_q.size()), 32'h0);
      chk("sb_fetches_left", 32'(fetch_q.size()), 32'h0);
      chk("ld_req_cycles",   slow_req_cnt, 32'd4);
      chk("rA_final",   32'(rf[10]), 32'h125C);
      chk("r3_final",   32'(rf[3]),  32'hBEEF);
      chk("sp_final",   32'(rf[2]),  32'h0100);
      chk("ra_final",   32'(rf[4]),  32'h0011);
      chk("pc_final",   32'(rf[1]),  32'h0043);
      chk("push_mem",   32'(mem[16'h0100]), 32'hCAFE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Upstream sequencer for the 16-entry register file: fetches a 16-bit instruction word, decodes it and drives every register-file control (src_sel, dst_sel, in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec).
- Also generates the register write-data mux select, the memory request/handshake and the ALU opcode.
- Reads the register file's src/dst buses back to form memory address and store data.
- Multi-cycle FSM, one instruction at a time, no pipelining.

Parameters:
- PC_IDX, 1, register index of program counter
- SP_IDX, 2, register index of stack pointer
- RA_IDX, 4, register index of return address

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- src  input  16  register-file src read bus
- dst  input  16  register-file dst read bus
- alu_zero  input  1  ALU result == 0 for current ALU op
- mem_rdata  input  16  memory read data
- mem_ready  input  1  memory completes request this cycle
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  1 = write, 0 = read; valid with mem_req
- mem_addr  output  16  = dst when addr_from_dst, else src (combinational)
- mem_wdata  output  16  = src
- src_sel  output  4  register-file src index
- dst_sel  output  4  register-file dst index
- in_en, up_en, lo_en  output  1 each  register-file write strobes
- pc_inc, sp_inc, sp_dec  output  1 each  register-file increment/decrement strobes
- in_sel  output  2  write mux: 0 ALU, 1 mem_rdata, 2 imm8 (zero-extended), 3 src
- imm8  output  8  ir[7:0]
- alu_op  output  4  ir[3:0]
- halted  output  1  high in HALT state

Behaviour:
- Instruction register (IR) fields:
  - ir[15:12] op
  - ir[11:8] rd
  - ir[7:4] rs
  - ir[7:0] imm8
  - ir[3:0] alu_op
- Opcodes:
  - 0 NOP
  - 1 MOV rd<-rs
  - 2 LDL rd[7:0]<-imm8
  - 3 LDU rd[15:8]<-imm8
  - 4 ALU rd<-alu(rd,rs), Z<-alu_zero
  - 5 LD rd<-mem[rs]
  - 6 ST mem[rd]<-rs
  - 7 PUSH mem[SP]<-rs; SP-1
  - 8 POP SP+1; rd<-mem[SP]
  - 9 JMP PC<-rs
  - A BZ if Z then PC<-rs
  - B CALL RA<-PC; PC<-rs
  - F HALT
  - C,D,E execute as NOP
- States: FETCH, EXEC, MEM, CALL2, HALT.
- Reset (async, rst_n=0):
  - state=FETCH, IR=0, Z=0.
  - All strobes, mem_req, mem_we, halted = 0.
  - src_sel=dst_sel=0, in_sel=0.
  - Reset mid-memory-request drops mem_req immediately; the request is abandoned.
- FETCH:
  - dst_sel=PC_IDX, mem_addr=dst, mem_req=1, mem_we=0.
  - On mem_ready: IR<=mem_rdata, pc_inc=1 same cycle, next EXEC. Otherwise hold.
- EXEC, single-cycle ops (1,2,3,4,9,A,NOP): drive strobes for exactly one cycle, then FETCH.
  - MOV, JMP: in_sel=3, in_en=1.
  - LDL: in_sel=2, lo_en. LDU: in_sel=2, up_en.
  - ALU: in_sel=0, in_en, Z latched.
  - BZ with Z=0: no strobes.
- Memory ops (5,6,7,8): EXEC sets up, MEM holds mem_req until mem_ready.
  - LD: in_sel=1, in_en only on the mem_ready cycle.
  - ST/PUSH: mem_we=1.
  - PUSH: dst_sel=SP_IDX for address; sp_dec on the mem_ready cycle.
  - POP: sp_inc in EXEC, load from the new SP in MEM. dst_sel switches SP_IDX->rd only on the write cycle, so the address uses src_sel=SP_IDX.
  - MEM always returns to FETCH.
- CALL:
  - EXEC: dst_sel=RA_IDX, src_sel=PC_IDX, in_sel=3, in_en.
  - CALL2: PC<-rs (in_sel=3, in_en), then FETCH.
  - RA receives the already-incremented PC.
- HALT: halted=1, no strobes, no mem_req; exits only on reset.
- Invariants:
  - pc_inc never coincides with an in_en whose dst_sel=PC_IDX.
  - sp_inc and sp_dec are never both high.
  - At most one of in_en/up_en/lo_en is high.
- rd=0 writes are issued; the register file discards them.
- Latency in cycles, zero-wait memory:
  - single-cycle ops 2
  - memory ops 3
  - CALL 3
- Each wait cycle on mem_ready adds one cycle.

Decomposition:
- Shared package tiny16_pkg:
  - opcode constants
  - in_sel encodings
  - FSM state enum
  - register index constants (PC/SP/BA/RA)
- Optional sub-module instr_decode: purely combinational, IR -> control bundle per state. The FSM and IR/Z registers stay in control_unit.

Test Plan:
- Reset with rst_n=0 mid-FETCH while mem_req=1 -> mem_req drops asynchronously. After release, first mem_addr = PC value 0x0000.
- Fetch 0x2A5C, then 0x3A12 -> lo_en then up_en with dst_sel=0xA, imm8 0x5C/0x12, in_sel=2. Each instruction takes 2 cycles.
- LD 0x5370 with mem_ready delayed 3 cycles -> mem_req held 4 cycles. in_en pulses once, on the ready cycle, with dst_sel=3, in_sel=1.
- PUSH 0x7050 with SP=0x0100 -> mem_addr=0x0100, mem_we=1, mem_wdata=r5, sp_dec one cycle. Then POP 0x8600 -> sp_inc, read at 0x0100, r6 written.
- CALL 0xB090 at PC=0x0010 -> RA written with 0x0011, then PC written with r9. pc_inc is never high during either write.
- ALU op yielding zero, then BZ 0xA070 -> PC<-r7. Repeat with alu_zero=0 -> no strobes, next fetch from PC+1. HALT 0xF000 -> halted=1, no further mem_req.
